// File: rtl/iiitb_countdown_timer_if.sv
// Control, preset and readout bundle of the BCD HH:MM:SS countdown timer.
// The master side drives load/run and the preset digits and observes the time and status.
// The slave side is the timer itself.
interface iiitb_countdown_timer_if;
    // control
    logic       load;
    logic       run;
    // preset digits (BCD)
    logic [3:0] p_hrm;
    logic [3:0] p_hrl;
    logic [3:0] p_minm;
    logic [3:0] p_minl;
    logic [3:0] p_secm;
    logic [3:0] p_secl;
    // remaining time (BCD), same six-nibble layout as the RTC readout
    logic [3:0] hrm;
    logic [3:0] hrl;
    logic [3:0] minm;
    logic [3:0] minl;
    logic [3:0] secm;
    logic [3:0] secl;
    // status
    logic       busy;
    logic       done;
    logic       expired;
    logic       load_err;

    modport master (
        output load, run, p_hrm, p_hrl, p_minm, p_minl, p_secm, p_secl,
        input  hrm, hrl, minm, minl, secm, secl, busy, done, expired, load_err
    );

    modport slave (
        input  load, run, p_hrm, p_hrl, p_minm, p_minl, p_secm, p_secl,
        output hrm, hrl, minm, minl, secm, secl, busy, done, expired, load_err
    );
endinterface

// File: rtl/iiitb_countdown_timer.sv
// BCD HH:MM:SS countdown timer. Loads a preset, decrements one second per clk_1hz edge
// while run is high, pulses done when it reaches 00:00:00 and optionally reloads the preset.
// Digit nibble index 0 = secl ... 5 = hrm throughout.
module iiitb_countdown_timer #(
    parameter int HR_MAX      = 23,
    parameter int AUTO_RELOAD = 0
) (
    input logic                   clk_1hz,
    input logic                   rst,
    iiitb_countdown_timer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    // Wrap value of each digit when it borrows (seconds/minutes tens wrap to 5).
    function automatic logic [3:0] digit_max(input int idx);
        case (idx)
            1, 3:    return 4'd5;
            default: return 4'd9;
        endcase
    endfunction

    logic [5:0][3:0] r_digits;
    logic [5:0][3:0] r_reload;
    state_t          r_state;
    logic            r_done;
    logic            r_load_err;
    logic            r_busy;
    logic            r_expired;

    logic [5:0][3:0] w_preset;
    logic [5:0][3:0] w_dec;
    logic [5:0]      w_borrow;
    logic [5:0][3:0] w_digits_next;
    logic [5:0][3:0] w_reload_next;
    state_t          w_state_next;
    logic            w_done_next;
    logic            w_load_err_next;
    logic            w_zero;
    logic            w_dec_zero;
    logic            w_preset_legal;
    logic [7:0]      w_preset_hours;

    assign w_preset = {bus.p_hrm, bus.p_hrl, bus.p_minm, bus.p_minl, bus.p_secm, bus.p_secl};

    // Hours are checked as a decimal value so HR_MAX may be any limit up to 99.
    assign w_preset_hours = ({4'd0, bus.p_hrm} * 8'd10) + {4'd0, bus.p_hrl};
    assign w_preset_legal = (bus.p_secl <= 4'd9) && (bus.p_secm <= 4'd5) &&
                            (bus.p_minl <= 4'd9) && (bus.p_minm <= 4'd5) &&
                            (bus.p_hrl  <= 4'd9) && (w_preset_hours <= 8'(HR_MAX));

    assign w_zero     = (r_digits == '0);
    assign w_dec_zero = (w_dec == '0);

    // Borrow ripples upward: a digit steps only when every lower digit is zero.
    // The top digit never wraps in practice because a step is only taken when T != 0.
    assign w_borrow[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < 6; gi++) begin : g_borrow
            assign w_borrow[gi] = w_borrow[gi-1] & (r_digits[gi-1] == 4'd0);
        end
        for (genvar gi = 0; gi < 6; gi++) begin : g_dec
            assign w_dec[gi] = !w_borrow[gi]          ? r_digits[gi] :
                               (r_digits[gi] == 4'd0) ? digit_max(gi) :
                                                        r_digits[gi] - 4'd1;
        end
    endgenerate

    // Next-state decision: load beats everything, then expiry/reload, then step, then pause.
    always_comb begin
        w_digits_next   = r_digits;
        w_reload_next   = r_reload;
        w_state_next    = r_state;
        w_done_next     = 1'b0;
        w_load_err_next = r_load_err;
        if (bus.load) begin
            if (w_preset_legal) begin
                w_digits_next   = w_preset;
                w_reload_next   = w_preset;
                w_state_next    = S_IDLE;
                w_load_err_next = 1'b0;
            end else begin
                w_load_err_next = 1'b1;
            end
        end else if (r_state == S_EXPIRED) begin
            // A zero reload value would expire again immediately, so it simply holds.
            if ((AUTO_RELOAD != 0) && (r_reload != '0)) begin
                w_digits_next = r_reload;
                w_state_next  = bus.run ? S_RUN : S_PAUSE;
            end
        end else if (bus.run) begin
            // With T already zero in IDLE/PAUSE nothing happens: no spurious done.
            if (!w_zero) begin
                w_digits_next = w_dec;
                if (w_dec_zero) begin
                    w_state_next = S_EXPIRED;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = S_RUN;
                end
            end
        end else if (r_state == S_RUN) begin
            w_state_next = S_PAUSE;
        end
    end

    // Timer FSM with registered time, reload value and status outputs.
    always_ff @(posedge clk_1hz) begin
        if (rst) begin
            r_digits   <= '0;
            r_reload   <= '0;
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            r_busy     <= 1'b0;
            r_expired  <= 1'b0;
        end else begin
            r_digits   <= w_digits_next;
            r_reload   <= w_reload_next;
            r_state    <= w_state_next;
            r_done     <= w_done_next;
            r_load_err <= w_load_err_next;
            r_busy     <= (w_state_next == S_RUN);
            r_expired  <= (w_state_next == S_EXPIRED);
        end
    end

    assign bus.hrm      = r_digits[5];
    assign bus.hrl      = r_digits[4];
    assign bus.minm     = r_digits[3];
    assign bus.minl     = r_digits[2];
    assign bus.secm     = r_digits[1];
    assign bus.secl     = r_digits[0];
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.expired  = r_expired;
    assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_iiitb_countdown_timer.sv
// Bench for the countdown timer: two instances (no reload / auto reload) share one stimulus
// stream and are checked every cycle against a seconds-based model, plus literal spot values.
module tb_iiitb_countdown_timer;

    logic        clk = 1'b0;
    logic        s_rst = 1'b0;
    logic        s_load = 1'b0;
    logic        s_run = 1'b0;
    logic [23:0] s_preset = '0;

    always #5 clk = ~clk;

    iiitb_countdown_timer_if ifa ();
    iiitb_countdown_timer_if ifb ();

    assign ifa.load   = s_load;
    assign ifa.run    = s_run;
    assign ifa.p_hrm  = s_preset[23:20];
    assign ifa.p_hrl  = s_preset[19:16];
    assign ifa.p_minm = s_preset[15:12];
    assign ifa.p_minl = s_preset[11:8];
    assign ifa.p_secm = s_preset[7:4];
    assign ifa.p_secl = s_preset[3:0];
    assign ifb.load   = s_load;
    assign ifb.run    = s_run;
    assign ifb.p_hrm  = s_preset[23:20];
    assign ifb.p_hrl  = s_preset[19:16];
    assign ifb.p_minm = s_preset[15:12];
    assign ifb.p_minl = s_preset[11:8];
    assign ifb.p_secm = s_preset[7:4];
    assign ifb.p_secl = s_preset[3:0];

    iiitb_countdown_timer #(.HR_MAX(23), .AUTO_RELOAD(0)) dut_a (
        .clk_1hz (clk),
        .rst     (s_rst),
        .bus     (ifa)
    );

    iiitb_countdown_timer #(.HR_MAX(23), .AUTO_RELOAD(1)) dut_b (
        .clk_1hz (clk),
        .rst     (s_rst),
        .bus     (ifb)
    );

    // {busy, done, expired, load_err, hrm, hrl, minm, minl, secm, secl}
    logic [27:0] w_word [2];
    assign w_word[0] = {ifa.busy, ifa.done, ifa.expired, ifa.load_err,
                        ifa.hrm, ifa.hrl, ifa.minm, ifa.minl, ifa.secm, ifa.secl};
    assign w_word[1] = {ifb.busy, ifb.done, ifb.expired, ifb.load_err,
                        ifb.hrm, ifb.hrl, ifb.minm, ifb.minl, ifb.secm, ifb.secl};

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- behavioural model: time kept as plain seconds ----------------
    int m_secs   [2];
    int m_reload [2];
    bit m_busy   [2];
    bit m_done   [2];
    bit m_exp    [2];
    bit m_err    [2];
    bit m_valid = 1'b0;

    function automatic bit legal(input logic [23:0] p);
        int h;
        h = int'(p[23:20]) * 10 + int'(p[19:16]);
        return (p[19:16] <= 4'd9) && (p[15:12] <= 4'd5) && (p[11:8] <= 4'd9) &&
               (p[7:4] <= 4'd5) && (p[3:0] <= 4'd9) && (h <= 23);
    endfunction

    function automatic int to_secs(input logic [23:0] p);
        return (int'(p[23:20]) * 10 + int'(p[19:16])) * 3600 +
               (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 +
               int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [27:0] model_word(input int k);
        return {m_busy[k], m_done[k], m_exp[k], m_err[k], to_bcd(m_secs[k])};
    endfunction

    // Model advances on each timer edge from the inputs presented for that edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            if (s_rst) begin
                m_secs[k] = 0; m_reload[k] = 0;
                m_busy[k] = 1'b0; m_exp[k] = 1'b0; m_err[k] = 1'b0;
            end else if (s_load) begin
                if (legal(s_preset)) begin
                    m_secs[k]   = to_secs(s_preset);
                    m_reload[k] = m_secs[k];
                    m_busy[k]   = 1'b0;
                    m_exp[k]    = 1'b0;
                    m_err[k]    = 1'b0;
                end else begin
                    m_err[k] = 1'b1;
                end
            end else if (m_exp[k]) begin
                if (k == 1 && m_reload[k] != 0) begin
                    m_secs[k] = m_reload[k];
                    m_exp[k]  = 1'b0;
                    m_busy[k] = s_run;
                end
            end else if (s_run && m_secs[k] != 0) begin
                m_secs[k] = m_secs[k] - 1;
                if (m_secs[k] == 0) begin
                    m_done[k] = 1'b1; m_exp[k] = 1'b1; m_busy[k] = 1'b0;
                end else begin
                    m_busy[k] = 1'b1;
                end
            end else if (!s_run) begin
                m_busy[k] = 1'b0;
            end
        end
        if (s_rst) m_valid = 1'b1;
    end

    task automatic chk(input string name, input logic [27:0] got, input logic [27:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cycle_noreload", w_word[0], model_word(0));
            chk("cycle_autoreload", w_word[1], model_word(1));
        end
    end

    // One timer edge with the given inputs; returns on the following falling edge.
    task automatic drive(input bit r, input bit l, input bit ru, input logic [23:0] p);
        s_rst = r; s_load = l; s_run = ru; s_preset = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Literal spot check of one instance; pins both the DUT and the model.
    task automatic lit(input string name, input int k, input logic [3:0] flags, input logic [23:0] dig);
        logic [27:0] exp;
        exp = {flags, dig};
        chk(name, w_word[k], exp);
        chk({name, "_model"}, model_word(k), exp);
    endtask

    initial begin
        @(negedge clk);
        drive(1, 0, 0, 24'h0);
        lit("reset_a", 0, 4'b0000, 24'h000000);
        lit("reset_b", 1, 4'b0000, 24'h000000);
        drive(0, 1, 1, 24'h000003);
        lit("load_beats_run", 0, 4'b0000, 24'h000003);
        drive(0, 0, 1, 24'h0);  lit("cd_2", 0, 4'b1000, 24'h000002);
        drive(0, 0, 1, 24'h0);  lit("cd_1", 0, 4'b1000, 24'h000001);
        drive(0, 0, 1, 24'h0);  lit("cd_done", 0, 4'b0110, 24'h000000);
        lit("cd_done_b", 1, 4'b0110, 24'h000000);
        drive(0, 0, 1, 24'h0);  lit("expired_hold", 0, 4'b0010, 24'h000000);
        lit("reload_b", 1, 4'b1000, 24'h000003);
        drive(0, 1, 0, 24'h100000);
        drive(0, 0, 1, 24'h0);  lit("borrow_hr", 0, 4'b1000, 24'h095959);
        drive(0, 1, 0, 24'h001000);
        drive(0, 0, 1, 24'h0);  lit("borrow_min", 0, 4'b1000, 24'h000959);
        drive(0, 1, 0, 24'h006000); lit("bad_min", 0, 4'b1001, 24'h000959);
        drive(0, 1, 0, 24'h240000); lit("bad_hr24", 0, 4'b1001, 24'h000959);
        drive(0, 1, 0, 24'h235959); lit("max_legal", 0, 4'b0000, 24'h235959);
        drive(0, 1, 0, 24'h000005);
        drive(0, 0, 1, 24'h0);
        drive(0, 0, 1, 24'h0);  lit("run_two", 0, 4'b1000, 24'h000003);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 24'h0);
            lit("pause_hold", 0, 4'b0000, 24'h000003);
        end
        drive(0, 0, 1, 24'h0);  lit("resume", 0, 4'b1000, 24'h000002);
        drive(0, 1, 0, 24'h000000);
        drive(0, 0, 1, 24'h0);  lit("zero_run_a", 0, 4'b0000, 24'h000000);
        drive(0, 0, 1, 24'h0);  lit("zero_run_b", 1, 4'b0000, 24'h000000);
        drive(0, 1, 0, 24'h000002);
        drive(0, 0, 1, 24'h0);  lit("auto_1", 1, 4'b1000, 24'h000001);
        drive(0, 0, 1, 24'h0);  lit("auto_done", 1, 4'b0110, 24'h000000);
        drive(0, 0, 1, 24'h0);  lit("auto_reload", 1, 4'b1000, 24'h000002);
        drive(0, 0, 1, 24'h0);  lit("auto_1b", 1, 4'b1000, 24'h000001);
        drive(0, 0, 1, 24'h0);  lit("auto_done2", 1, 4'b0110, 24'h000000);
        drive(0, 0, 0, 24'h0);  lit("auto_reload_pause", 1, 4'b0000, 24'h000002);
        lit("noreload_stays", 0, 4'b0010, 24'h000000);
        drive(0, 1, 0, 24'h000030);
        drive(0, 0, 1, 24'h0);
        drive(0, 1, 1, 24'h990000); lit("bad_hr99", 0, 4'b1001, 24'h000029);
        drive(1, 1, 1, 24'h000030); lit("rst_wins_a", 0, 4'b0000, 24'h000000);
        lit("rst_wins_b", 1, 4'b0000, 24'h000000);

        // Randomised phase: short presets so expiry and reload happen often.
        for (int i = 0; i < 4000; i++) begin
            logic [23:0] p;
            case ($urandom_range(0, 2))
                0:       p = 24'($urandom);
                1:       p = to_bcd(int'($urandom_range(0, 12)));
                default: p = to_bcd(int'($urandom_range(0, 86399)));
            endcase
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, p);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
